// File: rtl/inst_dispatch_ctrl_if.sv
// Instruction dispatch bus: command FIFO pop side, decoder word, alpha strobe,
// rasterizer handshake and status, seen from the controller (slave) or its environment (master).
interface inst_dispatch_ctrl_if #(
  parameter int DATA_W = 82
);
  logic              run;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_ren;
  logic [DATA_W-1:0] inst_reg;
  logic              alpha_wen;
  logic              draw_start;
  logic              draw_tri;
  logic              draw_done;
  logic              busy;
  logic [15:0]       inst_count;
  logic              err;

  modport slave (
    input  run, fifo_empty, fifo_rdata, draw_done,
    output fifo_ren, inst_reg, alpha_wen, draw_start, draw_tri, busy, inst_count, err
  );

  modport master (
    output run, fifo_empty, fifo_rdata, draw_done,
    input  fifo_ren, inst_reg, alpha_wen, draw_start, draw_tri, busy, inst_count, err
  );
endinterface

// File: rtl/inst_dispatch_ctrl.sv
// Pops one instruction word at a time, holds it for the decoder and dispatches it
// as an alpha write or a rasterizer draw, with an issue counter and a draw watchdog.
module inst_dispatch_ctrl #(
  parameter int DATA_W  = 82,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 n_rst,
  inst_dispatch_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POP       = 3'd1,
    LATCH     = 3'd2,
    DECODE    = 3'd3,
    ALPHA     = 3'd4,
    ISSUE     = 3'd5,
    WAIT_DRAW = 3'd6
  } state_t;

  localparam int              WD_W    = $clog2(TIMEOUT) + 1;
  // Last WAIT_DRAW cycle: the counter is about to reach TIMEOUT-1.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

  state_t            state_r;
  state_t            state_s;
  logic              timeout_s;
  logic [WD_W-1:0]   wd_cnt_r;
  logic [DATA_W-1:0] inst_reg_r;
  logic              fifo_ren_r;
  logic              alpha_wen_r;
  logic              draw_start_r;
  logic              draw_tri_r;
  logic              busy_r;
  logic              err_r;
  logic [15:0]       inst_count_r;

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and watchdog expiry detection.
  always_comb begin
    state_s   = state_r;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.run && !bus.fifo_empty && !err_r) begin
          state_s = POP;
        end else begin
          state_s = IDLE;
        end
      end
      POP:    state_s = LATCH;
      LATCH:  state_s = DECODE;
      DECODE: begin
        if (inst_reg_r[0]) begin
          state_s = ALPHA;
        end else begin
          state_s = ISSUE;
        end
      end
      ALPHA:  state_s = IDLE;
      ISSUE:  state_s = WAIT_DRAW;
      WAIT_DRAW: begin
        if (bus.draw_done) begin
          state_s = IDLE;
        end else if (wd_cnt_r == WD_LAST) begin
          state_s   = IDLE;
          timeout_s = 1'b1;
        end else begin
          state_s = WAIT_DRAW;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Moore strobes registered from the next state so they line up with the state itself.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fifo_ren_r   <= 1'b0;
      alpha_wen_r  <= 1'b0;
      draw_start_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      fifo_ren_r   <= (state_s == POP);
      alpha_wen_r  <= (state_s == ALPHA);
      draw_start_r <= (state_s == ISSUE);
      busy_r       <= (state_s != IDLE);
    end
  end

  // Instruction word hold register and triangle flag for the rasterizer.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      inst_reg_r <= '0;
      draw_tri_r <= 1'b0;
    end else begin
      if (state_r == LATCH) begin
        inst_reg_r <= bus.fifo_rdata;
      end
      if ((state_r == DECODE) && !inst_reg_r[0]) begin
        draw_tri_r <= inst_reg_r[1];
      end
    end
  end

  // Dispatch counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      inst_count_r <= 16'd0;
    end else if ((state_r == ALPHA) || (state_r == ISSUE)) begin
      inst_count_r <= inst_count_r + 16'd1;
    end
  end

  // Draw watchdog and its sticky error flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_cnt_r <= '0;
      err_r    <= 1'b0;
    end else begin
      if (state_r == ISSUE) begin
        wd_cnt_r <= '0;
      end else if (state_r == WAIT_DRAW) begin
        wd_cnt_r <= wd_cnt_r + WD_W'(1);
      end
      if (timeout_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign bus.fifo_ren   = fifo_ren_r;
  assign bus.inst_reg   = inst_reg_r;
  assign bus.alpha_wen  = alpha_wen_r;
  assign bus.draw_start = draw_start_r;
  assign bus.draw_tri   = draw_tri_r;
  assign bus.busy       = busy_r;
  assign bus.inst_count = inst_count_r;
  assign bus.err        = err_r;

endmodule
